// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader: word width and sequencer states.
package rom_stream_reader_pkg;
  localparam int DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rom_stream_reader_rd_fifo.sv
// Small shift-style capture FIFO whose entry 0 is the registered stream head.
module rom_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [WIDTH-1:0] shifted  [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             valid_reg;
  logic             pop_en;
  logic             push_en;

  assign pop_en  = pop & valid_reg;
  assign push_en = push & ((int'(count_reg) < DEPTH) | pop_en);

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != '0);
    end
  end

  // On pop every entry takes its successor; a push lands just past the surviving entries.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi < DEPTH - 1) begin : g_mid
        assign shifted[gi] = data_reg[gi+1];
      end else begin : g_tail
        assign shifted[gi] = '0;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg[gi] <= '0;
        end else if (pop_en) begin
          if (push_en && gi == int'(count_reg) - 1)
            data_reg[gi] <= push_data;
          else if (gi < int'(count_reg) - 1)
            data_reg[gi] <= shifted[gi];
        end else if (push_en && gi == int'(count_reg)) begin
          data_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  assign head_data  = data_reg[0];
  assign head_valid = valid_reg;
  assign count      = count_reg;
endmodule

// File: rtl/rom_stream_reader.sv
// Reads a run of consecutive ROM words and streams them out over valid/ready,
// hiding the ROM's one-cycle registered read latency behind a small capture FIFO.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_cs,
  output logic                 rom_oe,
  output logic [ADDR_BITS-1:0] rom_a,
  input  logic [DATA_BITS-1:0] rom_do,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [ADDR_BITS:0]   len_reg;
  logic [ADDR_BITS:0]   issue_cnt_reg;
  logic [ADDR_BITS:0]   ret_cnt_reg;
  logic                 rom_oe_reg;

  logic [DATA_BITS:0]   head_data;
  logic                 head_valid;
  logic [CW-1:0]        fifo_count;
  logic                 pop;
  logic                 issue_ok;
  logic                 last_issue;
  logic                 push_last;
  logic [CW:0]          occupancy;

  assign pop       = head_valid & out_ready;
  // Slots already committed: stored words plus the read returning this cycle, less the word leaving.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(rom_oe_reg) - (CW+1)'(pop);
  assign issue_ok  = occupancy < (CW+1)'(FIFO_DEPTH);
  assign push_last = (ret_cnt_reg == len_reg - 1'b1);

  always_comb begin
    state_next = state_reg;
    rom_cs     = 1'b0;
    last_issue = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        rom_cs     = issue_ok;
        last_issue = issue_ok && (issue_cnt_reg == len_reg - 1'b1);
        if (last_issue)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && head_data[DATA_BITS])
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      rom_oe_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rom_oe_reg <= rom_cs;
      if (state_reg == IDLE && start) begin
        addr_reg      <= start_addr;
        len_reg       <= length;
        issue_cnt_reg <= '0;
        ret_cnt_reg   <= '0;
      end else begin
        if (rom_cs) begin
          addr_reg      <= addr_reg + 1'b1;
          issue_cnt_reg <= issue_cnt_reg + 1'b1;
        end
        if (rom_oe_reg)
          ret_cnt_reg <= ret_cnt_reg + 1'b1;
      end
    end
  end

  rom_rd_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rom_oe_reg),
    .push_data  ({push_last, rom_do}),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign rom_oe    = rom_oe_reg;
  assign rom_a     = addr_reg;
  assign out_data  = head_data[DATA_BITS-1:0];
  assign out_valid = head_valid;
  assign out_last  = head_data[DATA_BITS] & head_valid;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: a table of transfers plus hand-written
// sequences for exact latency, zero length, mid-transfer reset and ignored restarts.
module tb_rom_stream_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        busy, done, rom_cs, rom_oe, out_valid, out_ready, out_last;
  logic [9:0]  rom_a;
  logic [31:0] rom_do;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_BITS(10), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rom_cs     (rom_cs),
    .rom_oe     (rom_oe),
    .rom_a      (rom_a),
    .rom_do     (rom_do),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  // ROM macro model: registered read when CS is high.
  always @(posedge clk) begin
    if (rom_cs) rom_do <= mem[rom_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stall stability and FIFO bound, observed mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data_stable", out_data, prev_data);
        chk("stall_last_stable", 32'(out_last), 32'(prev_last));
      end
      chk("fifo_bound", 32'(dut.u_fifo.count_reg <= 2'd2), 32'd1);
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
    end
  end

  typedef struct {
    logic [9:0]  addr;
    logic [10:0] len;
    logic [3:0]  ready_pat;
    bit          restart;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  // Runs one transfer, checking address order, data order, last marker and a single done.
  task automatic run_xfer(input vec_t v, input string tag);
    int got = 0;
    int iss = 0;
    int dones = 0;
    int budget;
    logic [9:0]  idx;
    logic [31:0] first_w = 0;
    logic [31:0] last_w = 0;
    budget = 4 * int'(v.len) + 40;
    start_addr = v.addr; length = v.len; start = 1'b1; out_ready = v.ready_pat[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < budget && dones == 0; cyc++) begin
      out_ready = v.ready_pat[cyc % 4];
      if (v.restart && cyc == 1) begin
        start = 1'b1; start_addr = v.addr + 10'd200; length = 11'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (rom_cs) begin
        idx = v.addr + 10'(iss);
        chk({tag, "_rom_a"}, 32'(rom_a), 32'(idx));
        iss++;
      end
      if (out_valid && out_ready) begin
        idx = v.addr + 10'(got);
        chk({tag, "_word"}, out_data, 32'(idx) * 32'd3);
        chk({tag, "_last"}, 32'(out_last), 32'(got == int'(v.len) - 1));
        if (got == 0) first_w = out_data;
        last_w = out_data;
        got++;
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'(v.len));
    chk({tag, "_issued"}, 32'(iss), 32'(v.len));
    chk({tag, "_done"}, 32'(dones), 32'd1);
    chk({tag, "_first"}, first_w, v.exp_first);
    chk({tag, "_lastw"}, last_w, v.exp_last);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [5];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'd3;

    vecs[0] = '{addr: 10'd5,    len: 11'd4, ready_pat: 4'b1111, restart: 1'b0, exp_first: 32'd15,   exp_last: 32'd24};
    vecs[1] = '{addr: 10'd1022, len: 11'd4, ready_pat: 4'b1111, restart: 1'b0, exp_first: 32'd3066, exp_last: 32'd3};
    vecs[2] = '{addr: 10'd300,  len: 11'd8, ready_pat: 4'b1001, restart: 1'b0, exp_first: 32'd900,  exp_last: 32'd921};
    vecs[3] = '{addr: 10'd20,   len: 11'd5, ready_pat: 4'b1111, restart: 1'b1, exp_first: 32'd60,   exp_last: 32'd72};
    vecs[4] = '{addr: 10'd1000, len: 11'd1, ready_pat: 4'b0110, restart: 1'b0, exp_first: 32'd3000, exp_last: 32'd3000};

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;

    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cs", 32'(rom_cs), 32'd0);
    chk("reset_oe", 32'(rom_oe), 32'd0);
    chk("reset_a", 32'(rom_a), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_last", 32'(out_last), 32'd0);

    // Exact cycle timing: addr 5, length 4, consumer always ready.
    start_addr = 10'd5; length = 11'd4; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    chk("t1_c1_cs", 32'(rom_cs), 32'd1);
    chk("t1_c1_a", 32'(rom_a), 32'd5);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    chk("t1_c2_oe", 32'(rom_oe), 32'd1);
    chk("t1_c2_valid", 32'(out_valid), 32'd0);
    for (int c = 3; c <= 6; c++) begin
      @(posedge clk); #2;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data", out_data, 32'd15 + 32'(c - 3) * 32'd3);
      chk("t1_last", 32'(out_last), 32'(c == 6));
      chk("t1_done_early", 32'(done), 32'd0);
    end
    @(posedge clk); #2;
    chk("t1_c7_done", 32'(done), 32'd1);
    chk("t1_c7_busy", 32'(busy), 32'd0);
    chk("t1_c7_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    chk("t1_c8_done", 32'(done), 32'd0);

    // Zero length: done the next cycle, no ROM activity.
    start_addr = 10'd77; length = 11'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cs", 32'(rom_cs), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("t2_done_once", 32'(done), 32'd0);
      chk("t2_oe", 32'(rom_oe), 32'd0);
      chk("t2_cs_idle", 32'(rom_cs), 32'd0);
      chk("t2_valid", 32'(out_valid), 32'd0);
    end

    // Table of full transfers.
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in cycle 4 of a length-16 transfer, then a clean follow-up transfer.
    start_addr = 10'd40; length = 11'd16; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_cs", 32'(rom_cs), 32'd0);
    chk("t5_oe", 32'(rom_oe), 32'd0);
    chk("t5_a", 32'(rom_a), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_last", 32'(out_last), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk("t5_quiet_valid", 32'(out_valid), 32'd0);
      chk("t5_quiet_done", 32'(done), 32'd0);
    end
    run_xfer('{addr: 10'd100, len: 11'd3, ready_pat: 4'b1111, restart: 1'b0,
               exp_first: 32'd300, exp_last: 32'd306}, "t5_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
